// File: rtl/dk_ioctl_pkg.sv
// Shared definitions for the HPS ioctl channel blocks.
//   ioctl_state_e : reader FSM states (idle, CPU pause handshake, armed, fetch in flight).
//   Index*        : ioctl_index values used by the top level (ROM download, NVRAM, DIPs).
package dk_ioctl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPause,
    StArmed,
    StFetch
  } ioctl_state_e;

  localparam logic [7:0] IndexRom   = 8'd0;
  localparam logic [7:0] IndexNvram = 8'd4;
  localparam logic [7:0] IndexDip   = 8'd254;

endpackage

// File: rtl/hiscore_uploader.sv
// Serves HPS ioctl upload requests for one ioctl_index by reading a game-RAM region
// (hiscore / NVRAM) through a dedicated RAM read port. The game CPU is paused for the whole
// upload so the snapshot is coherent.
//
// Parameters
//   INDEX  : ioctl_index this block answers to
//   AW     : RAM address width, region is 2**AW bytes (AW < 25)
//   RD_LAT : RAM read latency in clocks, 1..3
// Ports
//   I_CLK_24576M  in   system clock
//   I_RESETn      in   asynchronous active-low reset
//   ioctl_upload  in   high while an HPS upload is in progress
//   ioctl_rd      in   one-cycle byte request strobe
//   ioctl_addr    in   byte address of the request (25 bits)
//   ioctl_index   in   target index
//   ioctl_din     out  returned byte, held until the next fetch completes
//   ioctl_wait    out  HPS must not strobe ioctl_rd while high
//   O_PAUSE       out  CPU halt request
//   I_PAUSE_ACK   in   CPU halted
//   RAM_A         out  registered RAM read address
//   RAM_DO        in   RAM data, sampled RD_LAT clocks after RAM_A is loaded
//   O_DONE        out  one-cycle pulse after an upload ends
//   O_COUNT       out  bytes served in the current/last upload, saturating
//   O_OVERRUN     out  sticky: ioctl_rd seen while ioctl_wait was high
module hiscore_uploader
  import dk_ioctl_pkg::*;
#(
  parameter logic [7:0]  INDEX  = IndexNvram,
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          I_CLK_24576M,
  input  logic          I_RESETn,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_index,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          O_PAUSE,
  input  logic          I_PAUSE_ACK,
  output logic [AW-1:0] RAM_A,
  input  logic [7:0]    RAM_DO,
  output logic          O_DONE,
  output logic [AW:0]   O_COUNT,
  output logic          O_OVERRUN
);

  localparam logic [1:0] LatLoad  = 2'(RD_LAT);
  localparam logic [AW:0] CountOne = (AW + 1)'(1);

  ioctl_state_e  state_q, state_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic          oor_q, oor_d;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          pause_q, pause_d;
  logic          done_q, done_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          sel;

  assign sel = ioctl_upload & (ioctl_index == INDEX);

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q   <= StIdle;
      ram_a_q   <= '0;
      oor_q     <= 1'b0;
      lat_cnt_q <= '0;
      din_q     <= '0;
      wait_q    <= 1'b0;
      pause_q   <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_a_q   <= ram_a_d;
      oor_q     <= oor_d;
      lat_cnt_q <= lat_cnt_d;
      din_q     <= din_d;
      wait_q    <= wait_d;
      pause_q   <= pause_d;
      done_q    <= done_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_a_d   = ram_a_q;
    oor_d     = oor_q;
    lat_cnt_d = lat_cnt_q;
    din_d     = din_q;
    wait_d    = wait_q;
    pause_d   = pause_q;
    done_d    = 1'b0;
    count_d   = count_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (sel) begin
          state_d   = StPause;
          pause_d   = 1'b1;
          wait_d    = 1'b1;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end
      StPause: begin
        if (ioctl_rd) overrun_d = 1'b1;
        if (I_PAUSE_ACK) begin
          state_d = StArmed;
          wait_d  = 1'b0;
        end
      end
      StArmed: begin
        // Pause-ack dropping here is deliberately ignored: the halt request stays up.
        if (ioctl_rd) begin
          state_d   = StFetch;
          wait_d    = 1'b1;
          ram_a_d   = ioctl_addr[AW-1:0];
          oor_d     = |ioctl_addr[24:AW];
          lat_cnt_d = LatLoad;
        end
      end
      StFetch: begin
        if (ioctl_rd) overrun_d = 1'b1;
        lat_cnt_d = lat_cnt_q - 2'd1;
        // Out-of-range reads still wait the full latency so HPS timing is uniform.
        if (lat_cnt_q == 2'd1) begin
          din_d   = oor_q ? 8'hFF : RAM_DO;
          count_d = (count_q == '1) ? count_q : count_q + CountOne;
          wait_d  = 1'b0;
          state_d = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase

    // Upload end overrides everything above, including a coincident ioctl_rd:
    // an in-flight fetch is dropped and the returned byte/count stay as they were.
    if ((state_q != StIdle) && !sel) begin
      state_d   = StIdle;
      ram_a_d   = ram_a_q;
      oor_d     = oor_q;
      lat_cnt_d = lat_cnt_q;
      din_d     = din_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      pause_d   = 1'b0;
      wait_d    = 1'b0;
      done_d    = 1'b1;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign O_PAUSE    = pause_q;
  assign RAM_A      = ram_a_q;
  assign O_DONE     = done_q;
  assign O_COUNT    = count_q;
  assign O_OVERRUN  = overrun_q;

endmodule

// File: tb/tb_hiscore_uploader.sv
module tb_hiscore_uploader;

  localparam int unsigned AW     = 10;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned NBYTES = 1 << AW;

  logic        clk;
  logic        rst_n;
  logic        upload;
  logic        rd;
  logic [24:0] addr;
  logic [7:0]  index;
  logic [7:0]  din;
  logic        wt;
  logic        pause;
  logic        ack;
  logic [9:0]  ram_a;
  logic [7:0]  ram_do;
  logic        done;
  logic [10:0] count;
  logic        overrun;

  hiscore_uploader #(
    .INDEX (8'd4),
    .AW    (AW),
    .RD_LAT(RD_LAT)
  ) dut (
    .I_CLK_24576M(clk),
    .I_RESETn    (rst_n),
    .ioctl_upload(upload),
    .ioctl_rd    (rd),
    .ioctl_addr  (addr),
    .ioctl_index (index),
    .ioctl_din   (din),
    .ioctl_wait  (wt),
    .O_PAUSE     (pause),
    .I_PAUSE_ACK (ack),
    .RAM_A       (ram_a),
    .RAM_DO      (ram_do),
    .O_DONE      (done),
    .O_COUNT     (count),
    .O_OVERRUN   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game RAM with a two-clock read: one register stage after the DUT's registered address.
  logic [7:0] mem [NBYTES];
  logic [7:0] ram_q;
  always @(posedge clk) ram_q <= mem[ram_a];
  assign ram_do = ram_q;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state of the upload, derived from the request stream only.
  int         exp_count;
  logic [7:0] exp_din;
  logic [9:0] exp_ram_a;

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    if (a >= 25'(NBYTES)) return 8'hFF;
    return mem[a[9:0]];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_upload(input int ack_dly);
    upload = 1'b1; index = 8'd4; ack = 1'b0;
    tick;
    exp_count = 0;
    tests_run++;
    if (pause !== 1'b1 || wt !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_pause_wait: got pause=%b wait=%b want 1 1", pause, wt);
    end
    tests_run++;
    if (count !== 11'd0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_clear: got count=%0d overrun=%b want 0 0", count, overrun);
    end
    repeat (ack_dly) tick;
    tests_run++;
    if (wt !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_wait_held: got wait=%b want 1", wt);
    end
    ack = 1'b1;
    tick;
    tests_run++;
    if (wt !== 1'b0 || pause !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_release: got wait=%b pause=%b want 0 1", wt, pause);
    end
  endtask

  task automatic end_upload;
    upload = 1'b0; ack = 1'b0;
    tick;
    tests_run++;
    if (done !== 1'b1 || pause !== 1'b0 || wt !== 1'b0) begin
      tests_failed++;
      $display("FAIL end_upload: got done=%b pause=%b wait=%b want 1 0 0", done, pause, wt);
    end
    tick;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_width: got done=%b want 0", done);
    end
  endtask

  task automatic read_byte(input logic [24:0] a);
    rd = 1'b1; addr = a;
    tick;
    rd = 1'b0;
    exp_ram_a = a[9:0];
    tests_run++;
    if (ram_a !== exp_ram_a || wt !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_accept: got ram_a=%h wait=%b want %h 1", ram_a, wt, exp_ram_a);
    end
    for (int k = 1; k < RD_LAT; k++) begin
      tick;
      tests_run++;
      if (wt !== 1'b1) begin
        tests_failed++;
        $display("FAIL fetch_wait: got wait=%b want 1 at +%0d", wt, k);
      end
    end
    tick;
    exp_din = ref_byte(a);
    if (exp_count < 2047) exp_count++;
    tests_run++;
    if (din !== exp_din || wt !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_data @%h: got din=%h wait=%b want %h 0", a, din, wt, exp_din);
    end
    tests_run++;
    if (count !== 11'(exp_count)) begin
      tests_failed++;
      $display("FAIL rd_count: got %0d want %0d", count, exp_count);
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if (din !== 8'h00 || wt !== 1'b0 || pause !== 1'b0 || ram_a !== 10'h000 ||
        done !== 1'b0 || count !== 11'd0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got din=%h wait=%b pause=%b ram_a=%h done=%b count=%0d ovr=%b want all 0",
               din, wt, pause, ram_a, done, count, overrun);
    end
    rst_n = 1'b1;
    tick;
    tests_run++;
    if (pause !== 1'b0 || wt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got pause=%b wait=%b want 0 0", pause, wt);
    end
  endtask

  task automatic test_basic_read;
    mem[10'h012] = 8'h5A;
    start_upload(5);
    read_byte(25'h012);
    tests_run++;
    if (din !== 8'h5A || count !== 11'd1) begin
      tests_failed++;
      $display("FAIL basic_read: got din=%h count=%0d want 5a 1", din, count);
    end
    end_upload;
  endtask

  task automatic test_sequential;
    start_upload(1);
    for (int a = 0; a < int'(NBYTES); a++) read_byte(25'(a));
    tests_run++;
    if (count !== 11'd1024 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_totals: got count=%0d overrun=%b want 1024 0", count, overrun);
    end
    end_upload;
  endtask

  task automatic test_out_of_range;
    start_upload(0);
    read_byte(25'h400);
    tests_run++;
    if (din !== 8'hFF) begin
      tests_failed++;
      $display("FAIL oor_400: got %h want ff", din);
    end
    read_byte(25'h1ABCDEF);
    read_byte(25'h0000_7FF);
    end_upload;
  endtask

  task automatic test_overrun;
    logic [24:0] a1;
    // rd while waiting for the pause ack
    upload = 1'b1; index = 8'd4; ack = 1'b0;
    tick;
    exp_count = 0;
    rd = 1'b1; addr = 25'h3;
    tick;
    rd = 1'b0;
    tests_run++;
    if (overrun !== 1'b1 || wt !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_pause: got overrun=%b wait=%b want 1 1", overrun, wt);
    end
    end_upload;
    start_upload(2);
    // second rd one cycle into a fetch
    a1 = 25'($urandom_range(0, NBYTES - 1));
    rd = 1'b1; addr = a1;
    tick;
    addr = a1 ^ 25'h155;
    tick;
    rd = 1'b0;
    tests_run++;
    if (overrun !== 1'b1 || ram_a !== a1[9:0]) begin
      tests_failed++;
      $display("FAIL overrun_fetch: got overrun=%b ram_a=%h want 1 %h", overrun, ram_a, a1[9:0]);
    end
    repeat (RD_LAT - 1) tick;
    exp_din = ref_byte(a1);
    exp_count = 1;
    repeat (3) tick;
    tests_run++;
    if (din !== exp_din || count !== 11'd1 || wt !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_single: got din=%h count=%0d wait=%b want %h 1 0",
               din, count, wt, exp_din);
    end
    end_upload;
    start_upload(0);
    end_upload;
  endtask

  task automatic test_other_index;
    logic [9:0] ram_a_before;
    logic [7:0] din_before;
    ram_a_before = ram_a;
    din_before = din;
    upload = 1'b1; index = 8'd1; ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(0, 1));
      addr = 25'($urandom);
      tick;
      tests_run++;
      if (pause !== 1'b0 || wt !== 1'b0 || done !== 1'b0 || count !== 11'(exp_count) ||
          ram_a !== ram_a_before || din !== din_before) begin
        tests_failed++;
        $display("FAIL other_index: got pause=%b wait=%b done=%b count=%0d ram_a=%h din=%h want 0 0 0 %0d %h %h",
                 pause, wt, done, count, ram_a, din, exp_count, ram_a_before, din_before);
      end
    end
    rd = 1'b0; upload = 1'b0; ack = 1'b0;
    tick;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL other_index_done: got %b want 0", done);
    end
  endtask

  task automatic test_abort_mid_fetch;
    start_upload(3);
    read_byte(25'($urandom_range(0, NBYTES - 1)));
    rd = 1'b1; addr = 25'($urandom_range(0, NBYTES - 1));
    tick;
    rd = 1'b0; upload = 1'b0; ack = 1'b0;
    tick;
    tests_run++;
    if (din !== exp_din || count !== 11'(exp_count) || done !== 1'b1 || pause !== 1'b0 ||
        wt !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_fetch: got din=%h count=%0d done=%b pause=%b wait=%b want %h %0d 1 0 0",
               din, count, done, pause, wt, exp_din, exp_count);
    end
    repeat (3) tick;
    tests_run++;
    if (din !== exp_din || count !== 11'(exp_count) || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_after: got din=%h count=%0d done=%b want %h %0d 0",
               din, count, done, exp_din, exp_count);
    end
  endtask

  task automatic test_rd_on_fall;
    start_upload(1);
    read_byte(25'h2A5);
    rd = 1'b1; addr = 25'h05A; upload = 1'b0; ack = 1'b0;
    tick;
    rd = 1'b0;
    tests_run++;
    if (ram_a !== exp_ram_a || done !== 1'b1 || wt !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_on_fall: got ram_a=%h done=%b wait=%b want %h 1 0", ram_a, done, wt, exp_ram_a);
    end
    repeat (RD_LAT + 1) tick;
    tests_run++;
    if (din !== exp_din || count !== 11'(exp_count)) begin
      tests_failed++;
      $display("FAIL rd_on_fall_data: got din=%h count=%0d want %h %0d", din, count, exp_din, exp_count);
    end
  endtask

  task automatic test_random;
    logic [24:0] a;
    start_upload(int'($urandom_range(0, 6)));
    for (int i = 0; i < 200; i++) begin
      // pause-ack wobble must not matter once armed
      ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 25'($urandom);
      else a = 25'($urandom_range(0, NBYTES - 1));
      repeat ($urandom_range(0, 2)) tick;
      read_byte(a);
    end
    tests_run++;
    if (count !== 11'd200 || overrun !== 1'b0 || pause !== 1'b1) begin
      tests_failed++;
      $display("FAIL random_totals: got count=%0d overrun=%b pause=%b want 200 0 1",
               count, overrun, pause);
    end
    end_upload;
  endtask

  task automatic test_reset_mid_fetch;
    start_upload(1);
    rd = 1'b1; addr = 25'h1F3;
    tick;
    rd = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (din !== 8'h00 || wt !== 1'b0 || pause !== 1'b0 || ram_a !== 10'h000 ||
        done !== 1'b0 || count !== 11'd0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_fetch: got din=%h wait=%b pause=%b ram_a=%h done=%b count=%0d ovr=%b want all 0",
               din, wt, pause, ram_a, done, count, overrun);
    end
    upload = 1'b0; ack = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    tests_run++;
    if (pause !== 1'b0 || wt !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got pause=%b wait=%b done=%b want 0 0 0", pause, wt, done);
    end
    start_upload(0);
    read_byte(25'h1F3);
    end_upload;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'($urandom);
    rst_n = 1'b0; upload = 1'b0; rd = 1'b0; addr = '0; index = '0; ack = 1'b0;
    exp_count = 0; exp_din = 8'h00; exp_ram_a = '0;
    repeat (3) tick;
    test_reset;
    test_basic_read;
    test_sequential;
    test_out_of_range;
    test_overrun;
    test_other_index;
    test_abort_mid_fetch;
    test_rd_on_fall;
    test_random;
    test_reset_mid_fetch;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
